// File: rtl/bcd_7seg.sv
// Registered BCD to seven-segment decoder with blank and lamp-test overrides.
// Define BCD_7SEG_HEX_EN to show hex glyphs A..F for codes 10..15 instead of flagging them invalid.
module bcd_7seg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] s,
  output logic       invalid
);

  // Segment order is {a,b,c,d,e,f,g}; 1 lights a segment.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
`ifdef BCD_7SEG_HEX_EN
      4'd10:   seg = 7'b1110111;
      4'd11:   seg = 7'b0011111;
      4'd12:   seg = 7'b1001110;
      4'd13:   seg = 7'b0111101;
      4'd14:   seg = 7'b1001111;
      4'd15:   seg = 7'b1000111;
`endif
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  logic [6:0] seg_s;
  logic       invalid_s;

  // Next segment pattern: lamp test beats blank, blank beats decode.
  always_comb begin
    seg_s = 7'b0000000;
    if (lamp_test) begin
      seg_s = 7'b1111111;
    end else if (blank) begin
      seg_s = 7'b0000000;
    end else begin
      seg_s = decode(bcd);
    end
  end

  // Invalid flag looks only at the digit, never at the overrides.
`ifdef BCD_7SEG_HEX_EN
  assign invalid_s = 1'b0;
`else
  assign invalid_s = (bcd > 4'd9);
`endif

  // Output register: synchronous reset, load on enable, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s       <= 7'b0000000;
      invalid <= 1'b0;
    end else if (en) begin
      s       <= seg_s;
      invalid <= invalid_s;
    end else begin
      s       <= s;
      invalid <= invalid;
    end
  end

endmodule

// File: tb/tb_bcd_7seg.sv
// Self-checking bench for bcd_7seg: directed vector table plus randomized run against a reference model.
// Expectations for codes 10..15 follow BCD_7SEG_HEX_EN when the bench is built with it.
module tb_bcd_7seg;

  logic       clk = 1'b0;
  logic       rst_n, en, blank, lamp_test;
  logic [3:0] bcd;
  logic [6:0] s;
  logic       invalid;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] bcd;
    logic       blank;
    logic       lamp_test;
    logic [6:0] exp_s;
    logic       exp_inv;
  } vec_t;

  vec_t vecs[$];
  logic [6:0] glyph [16];

  bcd_7seg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bcd       (bcd),
    .blank     (blank),
    .lamp_test (lamp_test),
    .s         (s),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic [3:0] b, input logic bl,
                     input logic lt, input logic [6:0] es, input logic ei);
    vec_t v;
    v.rst_n = r; v.en = e; v.bcd = b; v.blank = bl; v.lamp_test = lt;
    v.exp_s = es; v.exp_inv = ei;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [6:0] es, input logic ei);
    tests++;
    if (s !== es || invalid !== ei) begin
      fails++;
      $display("FAIL %s: got s=%b invalid=%b, expected s=%b invalid=%b", name, s, invalid, es, ei);
    end
  endtask

  // Apply one set of inputs for one clock edge, leaving the outputs settled after it.
  task automatic step(input logic r, input logic e, input logic [3:0] b, input logic bl, input logic lt);
    rst_n = r; en = e; bcd = b; blank = bl; lamp_test = lt;
    @(posedge clk);
    #1;
  endtask

  // Stimulus and checking.
  initial begin
    logic       m_inv;
    logic [6:0] m_s;
    logic       r, e, bl, lt;
    logic [3:0] b;
    logic       hex_mode;

`ifdef BCD_7SEG_HEX_EN
    hex_mode = 1'b1;
`else
    hex_mode = 1'b0;
`endif
    glyph[0]  = 7'b1111110; glyph[1]  = 7'b0110000; glyph[2]  = 7'b1101101;
    glyph[3]  = 7'b1111001; glyph[4]  = 7'b0110011; glyph[5]  = 7'b1011011;
    glyph[6]  = 7'b1011111; glyph[7]  = 7'b1110000; glyph[8]  = 7'b1111111;
    glyph[9]  = 7'b1111011; glyph[10] = 7'b1110111; glyph[11] = 7'b0011111;
    glyph[12] = 7'b1001110; glyph[13] = 7'b0111101; glyph[14] = 7'b1001111;
    glyph[15] = 7'b1000111;

    // Reset held two cycles with bcd=8 and en=1.
    add(1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 7'b0000000, 1'b0);
    add(1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 7'b0000000, 1'b0);
    // Decimal sweep.
    add(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 7'b1111110, 1'b0);
    add(1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 7'b0110000, 1'b0);
    add(1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 7'b1101101, 1'b0);
    add(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 7'b1111001, 1'b0);
    add(1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 7'b0110011, 1'b0);
    add(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 7'b1011011, 1'b0);
    add(1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 7'b1011111, 1'b0);
    add(1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 7'b1110000, 1'b0);
    add(1'b1, 1'b1, 4'd8, 1'b0, 1'b0, 7'b1111111, 1'b0);
    add(1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 7'b1111011, 1'b0);
    // Codes 10..15.
`ifdef BCD_7SEG_HEX_EN
    add(1'b1, 1'b1, 4'd10, 1'b0, 1'b0, 7'b1110111, 1'b0);
    add(1'b1, 1'b1, 4'd11, 1'b0, 1'b0, 7'b0011111, 1'b0);
    add(1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 7'b1001110, 1'b0);
    add(1'b1, 1'b1, 4'd13, 1'b0, 1'b0, 7'b0111101, 1'b0);
    add(1'b1, 1'b1, 4'd14, 1'b0, 1'b0, 7'b1001111, 1'b0);
    add(1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 7'b1000111, 1'b0);
    add(1'b1, 1'b1, 4'd12, 1'b1, 1'b0, 7'b0000000, 1'b0);
    add(1'b1, 1'b1, 4'd12, 1'b0, 1'b1, 7'b1111111, 1'b0);
`else
    for (int i = 10; i < 16; i++) add(1'b1, 1'b1, 4'(i), 1'b0, 1'b0, 7'b0000000, 1'b1);
    add(1'b1, 1'b1, 4'd12, 1'b1, 1'b0, 7'b0000000, 1'b1);
    add(1'b1, 1'b1, 4'd12, 1'b0, 1'b1, 7'b1111111, 1'b1);
`endif
    // Blank, then lamp test winning over blank.
    add(1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 7'b0000000, 1'b0);
    add(1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 7'b1111111, 1'b0);
    // Hold with en=0.
    add(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 7'b1011011, 1'b0);
    add(1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 7'b1011011, 1'b0);
    add(1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 7'b1011011, 1'b0);
    add(1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 7'b1011011, 1'b0);
    // Reset pulse mid-stream, also while en=0.
    add(1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 7'b1110000, 1'b0);
    add(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 7'b0000000, 1'b0);
    add(1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 7'b1110000, 1'b0);
    add(1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 7'b0000000, 1'b0);
    add(1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 7'b0000000, 1'b0);
    add(1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 7'b1110000, 1'b0);

    rst_n = 1'b0; en = 1'b0; bcd = 4'd0; blank = 1'b0; lamp_test = 1'b0;
    #1;
    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].en, vecs[i].bcd, vecs[i].blank, vecs[i].lamp_test);
      check($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_inv);
    end

    // Randomized run; the model starts from a forced reset.
    m_s = 7'b0000000; m_inv = 1'b0;
    for (int k = 0; k < 400; k++) begin
      r  = (k == 0) ? 1'b0 : ($urandom_range(15) != 0);
      e  = ($urandom_range(3) != 0);
      b  = 4'($urandom_range(15));
      bl = ($urandom_range(3) == 0);
      lt = ($urandom_range(7) == 0);
      if (!r) begin
        m_s = 7'b0000000; m_inv = 1'b0;
      end else if (e) begin
        m_inv = (int'(b) >= 10) && !hex_mode;
        if (lt) m_s = 7'b1111111;
        else if (bl) m_s = 7'b0000000;
        else if (int'(b) <= 9 || hex_mode) m_s = glyph[b];
        else m_s = 7'b0000000;
      end
      step(r, e, b, bl, lt);
      check($sformatf("rand%0d", k), m_s, m_inv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_7seg.md
BCD_7SEG -- requirements
Module: bcd_7seg

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 en  input  1  load enable; when 1, bcd/blank/lamp_test are captured on the clock edge.
REQ-005 bcd  input  4  BCD digit to decode.
REQ-006 blank  input  1  forces all segments off.
REQ-007 lamp_test  input  1  forces all segments on.
REQ-008 s  output  7  registered segment drive, s[6]=a, s[5]=b, s[4]=c, s[3]=d, s[2]=e, s[1]=f, s[0]=g; 1 = segment lit.
REQ-009 invalid  output  1  registered flag; 1 when the captured bcd is 10..15 and the display is not hex-decoded.
REQ-010 The block SHALL have no parameters.

Function
REQ-011 On each rising clk edge with rst_n=1 and en=1, s and invalid SHALL update from the current inputs; the latency is 1 cycle.
REQ-012 With en=0, s and invalid SHALL hold their previous values.
REQ-013 Output priority SHALL be: lamp_test (s=1111111) first, then blank (s=0000000), then normal decode.
REQ-014 Decode SHALL map digits 0..9 as follows: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-015 When bcd is 10..15, the response SHALL follow Configuration (REQ-021/022).
REQ-016 invalid SHALL be computed from bcd regardless of blank and lamp_test.
REQ-017 The outputs SHALL be purely registered, with no combinational path from the inputs to s or invalid.

Reset
REQ-018 When rst_n=0 at a rising clk edge, s SHALL become 0000000 and invalid SHALL become 0, regardless of en.
REQ-019 Reset SHALL take precedence over all other inputs; assertion mid-operation SHALL clear the outputs on the next edge.
REQ-020 Normal capture SHALL resume on the first edge with rst_n=1 and en=1.

Configuration
REQ-021 With BCD_7SEG_HEX_EN defined, codes 10..15 SHALL display hex glyphs A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111, and invalid SHALL be constantly 0.
REQ-022 Without BCD_7SEG_HEX_EN, codes 10..15 SHALL produce s=0000000 with invalid=1.

Verification
REQ-023 rst_n=0 for 2 cycles with bcd=8 and en=1 -> s=0000000, invalid=0.
REQ-024 en=1, sweep bcd 0..9 one per cycle -> one cycle later s matches the REQ-014 table and invalid=0.
REQ-025 Sweep bcd 10..15 -> macro off: s=0000000, invalid=1; macro on: hex glyphs per REQ-021, invalid=0.
REQ-026 bcd=3 with blank=1 -> s=0000000; then lamp_test=1 and blank=1 -> s=1111111.
REQ-027 Load bcd=5, then en=0 and bcd=2 for 3 cycles -> s stays 1011011.
REQ-028 bcd=7 with rst_n dropped for one cycle mid-stream -> s=0000000 for that cycle, then 1110000 after release.
